mem_copy_ctrl: RTL and testbench
================================

Name: mem_copy_ctrl

Overview:
Command/sequencing stage directly upstream of the 32x8 ROM → dual-port RAM path on the DE0 memory board. Conditions raw board switches and a push-button (2-flop synchronise, debounce, rising-edge detect). It drives the synchronous ROM address. It generates RAM write address/data/enable with correct alignment to the ROM's 1-cycle read latency. Supports a single manual write and a 32-entry auto-copy sweep (ROM[0..31] → RAM[0..31]).

Parameters:
D_WIDTH, 8, data width of ROM/RAM
A_WIDTH, 5, address width; sweep covers 0 .. 2^A_WIDTH-1
DB_CNT_W, 16, debounce counter width; input vector must be stable for 2^DB_CNT_W-1 consecutive cycles

Ports:
clk  input  1  system clock
n_rst  input  1  reset, asynchronous, active-low
sw_addr  input  A_WIDTH  raw switch address (asynchronous to clk)
sw_wr  input  1  raw manual-write switch; a rising edge requests one write
btn_copy  input  1  raw button, active-high; a rising edge starts a sweep
rom_addr  output  A_WIDTH  registered ROM address
rom_data  input  D_WIDTH  ROM q; valid 1 cycle after the address is presented
ram_waddr  output  A_WIDTH  registered RAM write address
ram_wdata  output  D_WIDTH  RAM write data, combinational pass-through of rom_data
ram_wen  output  1  registered RAM write enable
busy  output  1  high while a sweep is in progress (state != IDLE)
done  output  1  one-cycle pulse, coincident with the final sweep write

Behaviour:
- Reset (async): rom_addr=0, ram_waddr=0, ram_wen=0, busy=0, done=0, state=IDLE. Synchroniser, debounce counter and debounced vector are all 0. Edge-detect history is 0, so no edge is generated by reset release.
- Conditioning: vector v={btn_copy,sw_wr,sw_addr} passes through a 2-flop sync. If sync≠last, then last<=sync and cnt<=0. Otherwise, if cnt==all-ones, db<=last; else cnt++. The shared counter means a change on any bit restarts the count.
- Edges: wr_rise = db.wr & ~db_d.wr; cp_rise = db.cp & ~db_d.cp. Each edge is a single-cycle pulse and is consumed in the cycle it occurs.
- Read pipeline: rd_vld (register) marks that the current rom_addr is a requested read. At the next edge, addr_d<=rom_addr and vld_d<=rd_vld. Outputs: ram_waddr=addr_d, ram_wen=vld_d, ram_wdata=rom_data. These are inherently aligned.
- FSM states are IDLE, COPY and DRAIN.
- IDLE:
  - rom_addr<=db.addr every cycle (live display of the switch address).
  - cp_rise: state<=COPY, rom_addr<=0, rd_vld<=1.
  - Else wr_rise: rd_vld<=1 for exactly one cycle, rom_addr<=db.addr.
  - Else: rd_vld<=0.
- COPY:
  - rd_vld stays 1.
  - If rom_addr==2^A_WIDTH-1: state<=DRAIN, rd_vld<=0, rom_addr held. Else rom_addr<=rom_addr+1.
  - COPY lasts exactly 2^A_WIDTH cycles.
- DRAIN: final write occurs (ram_wen=1, ram_waddr=max), done=1. state<=IDLE.
- Latency, manual write: wr_rise in cycle T → rd_vld in T+1 → ram_wen=1 in T+2 only. ram_waddr=db.addr, ram_wdata=ROM[db.addr].
- Latency, sweep: cp_rise in cycle T → ram_wen high for T+2..T+2^A_WIDTH+1. That is 32 consecutive writes, with addresses 0..31 in order. busy is high for T+1..T+2^A_WIDTH+1. done is high only in the last of those cycles.
- Simultaneous cp_rise and wr_rise in IDLE: copy wins; the manual request is dropped.
- wr_rise or cp_rise while busy: ignored and not queued.
- Address wrap: the increment never wraps inside COPY, because the terminal check precedes the increment.
- Reset asserted mid-sweep: all outputs clear immediately (async); no further writes occur after release. Re-triggering requires a new button edge.
- A switch held steady across reset release produces no edge until it goes low, then high again.

Decomposition:
- Shared package (mem_pkg) holds:
  - state enum (IDLE=2'd0, COPY=2'd1, DRAIN=2'd2)
  - default widths D_WIDTH/A_WIDTH
  - debounce default DB_CNT_W
- One sub-module, sw_debounce (parameter W, DB_CNT_W): vector sync + shared-counter debounce, outputs db[W-1:0]. Edge detect and FSM stay in mem_copy_ctrl.

Test Plan:
All tests use DB_CNT_W=4 and a ROM model with ROM[i]=i^8'hA5.
1. Reset: hold n_rst=0 with inputs toggling → all outputs 0. Release with sw_wr=1 held → no ram_wen for 100 cycles.
2. Manual write: sw_addr=5'd7 stable, then sw_wr 0→1 → after debounce, exactly one ram_wen cycle with ram_waddr=7 and ram_wdata=8'hA2. rom_addr=7 throughout.
3. Sweep: btn_copy pulse held 20 cycles → 32 consecutive ram_wen cycles with ram_waddr 0..31 and ram_wdata=i^8'hA5. busy is 33 cycles wide; done is a single pulse with ram_waddr=31. Afterwards rom_addr returns to sw_addr.
4. Bounce: sw_wr chatter toggling every 3 cycles for 40 cycles, then stable high → exactly one write. Chatter shorter than 15 cycles alone → zero writes.
5. Collision: sw_wr and btn_copy rise in the same cycle → sweep only, no extra write. sw_wr edge mid-sweep → ignored, total writes = 32.
6. Reset mid-sweep: assert n_rst=0 at sweep write #10 → ram_wen drops asynchronously, busy=0. No writes after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the ROM -> RAM copy path.
// Imported by the command stage and its input conditioner.
package mem_pkg;

  localparam int D_WIDTH  = 8;
  localparam int A_WIDTH  = 5;
  localparam int DB_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COPY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus a shared-counter debouncer for a raw input vector.
// A change on any bit restarts the stability count for the whole vector.
module sw_debounce #(
  parameter int W        = 7,
  parameter int DB_CNT_W = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [W-1:0] v,
  output logic [W-1:0] db,
  output logic         settled
);

  logic [W-1:0]        s1;
  logic [W-1:0]        s2;
  logic [W-1:0]        last;
  logic [DB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1      <= '0;
      s2      <= '0;
      last    <= '0;
      cnt     <= '0;
      db      <= '0;
      settled <= 1'b0;
    end else begin
      s1 <= v;
      s2 <= s1;
      if (s2 != last) begin
        last <= s2;
        cnt  <= '0;
      end else if (cnt == '1) begin
        db      <= last;
        settled <= 1'b1;
      end else begin
        cnt <= cnt + DB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_copy_ctrl.sv
// Command stage for the ROM -> RAM copy path: conditions switches, drives the
// ROM address and issues RAM writes aligned to the ROM's one-cycle latency.
module mem_copy_ctrl
  import mem_pkg::*;
#(
  parameter int D_WIDTH  = mem_pkg::D_WIDTH,
  parameter int A_WIDTH  = mem_pkg::A_WIDTH,
  parameter int DB_CNT_W = mem_pkg::DB_CNT_W
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [A_WIDTH-1:0] sw_addr,
  input  logic               sw_wr,
  input  logic               btn_copy,
  output logic [A_WIDTH-1:0] rom_addr,
  input  logic [D_WIDTH-1:0] rom_data,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic [D_WIDTH-1:0] ram_wdata,
  output logic               ram_wen,
  output logic               busy,
  output logic               done
);

  localparam int W = A_WIDTH + 2;

  logic [W-1:0]       db;
  logic               settled;
  logic               armed;
  logic               wr_d;
  logic               cp_d;
  logic               rd_vld;
  logic               vld_d;
  logic [A_WIDTH-1:0] addr_d;
  state_t             state;

  logic [A_WIDTH-1:0] db_addr;
  logic               db_wr;
  logic               db_cp;
  logic               wr_rise;
  logic               cp_rise;

  sw_debounce #(
    .W        (W),
    .DB_CNT_W (DB_CNT_W)
  ) u_db (
    .clk     (clk),
    .n_rst   (n_rst),
    .v       ({btn_copy, sw_wr, sw_addr}),
    .db      (db),
    .settled (settled)
  );

  assign db_addr = db[A_WIDTH-1:0];
  assign db_wr   = db[A_WIDTH];
  assign db_cp   = db[A_WIDTH+1];

  // armed lags the first settle so a level held across reset is not an edge
  assign wr_rise = armed & db_wr & ~wr_d;
  assign cp_rise = armed & db_cp & ~cp_d;

  assign ram_waddr = addr_d;
  assign ram_wen   = vld_d;
  assign ram_wdata = rom_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      rd_vld   <= 1'b0;
      addr_d   <= '0;
      vld_d    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_d     <= 1'b0;
      cp_d     <= 1'b0;
      armed    <= 1'b0;
    end else begin
      wr_d   <= db_wr;
      cp_d   <= db_cp;
      armed  <= settled;
      addr_d <= rom_addr;
      vld_d  <= rd_vld;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          rom_addr <= db_addr;
          rd_vld   <= 1'b0;
          if (cp_rise) begin
            state    <= COPY;
            busy     <= 1'b1;
            rom_addr <= '0;
            rd_vld   <= 1'b1;
          end else if (wr_rise) begin
            rd_vld <= 1'b1;
          end
        end
        COPY: begin
          if (rom_addr == '1) begin
            state  <= DRAIN;
            rd_vld <= 1'b0;
            done   <= 1'b1;
          end else begin
            rom_addr <= rom_addr + A_WIDTH'(1);
          end
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          rd_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Directed bench for mem_copy_ctrl with a ROM model and a write scoreboard.
module tb_mem_copy_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [4:0] sw_addr = '0;
  logic       sw_wr = 1'b0;
  logic       btn_copy = 1'b0;
  logic [4:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic       ram_wen;
  logic       busy;
  logic       done;

  int vecs = 0;
  int errs = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [12:0] sb[$];

  always #5 clk = ~clk;

  mem_copy_ctrl #(
    .D_WIDTH  (8),
    .A_WIDTH  (5),
    .DB_CNT_W (4)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .sw_addr   (sw_addr),
    .sw_wr     (sw_wr),
    .btn_copy  (btn_copy),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .busy      (busy),
    .done      (done)
  );

  // synchronous ROM, ROM[i] = i ^ 8'hA5
  always @(posedge clk) rom_data <= {3'b000, rom_addr} ^ 8'hA5;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input int a);
    logic [4:0] a5;
    a5 = 5'(a);
    sb.push_back({a5, {3'b000, a5} ^ 8'hA5});
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 32; i++) push_wr(i);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_done(input int base, input int lim);
    int k;
    k = 0;
    while (done_cnt == base && k < lim) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", 32'(done_cnt != base), 1);
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      logic [12:0] e;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_wen", 32'(ram_wen), 1);
        chk("done_addr", 32'(ram_waddr), 31);
      end
      if (ram_wen) begin
        wr_cnt++;
        chk("sb_avail", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("wr_addr", 32'(ram_waddr), 32'(e[12:8]));
          chk("wr_data", 32'(ram_wdata), 32'(e[7:0]));
        end
      end
    end
  end

  initial begin
    int base;
    int dbase;
    logic hit;

    // 1: reset with toggling inputs, release with sw_wr held
    for (int i = 0; i < 8; i++) begin
      sw_addr  = 5'(i * 5);
      sw_wr    = i[0];
      btn_copy = i[1];
      @(negedge clk);
      chk("rst_rom_addr", 32'(rom_addr), 0);
    end
    chk("rst_waddr", 32'(ram_waddr), 0);
    chk("rst_wen", 32'(ram_wen), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    sw_addr  = 5'd0;
    sw_wr    = 1'b1;
    btn_copy = 1'b0;
    cycles(2);
    n_rst = 1'b1;
    cycles(100);
    chk("rel_no_wr", 32'(wr_cnt), 0);
    chk("rel_busy", 32'(busy), 0);

    // 2: manual write of address 7
    sw_wr   = 1'b0;
    sw_addr = 5'd7;
    cycles(30);
    chk("idle_rom_addr", 32'(rom_addr), 7);
    base = wr_cnt;
    push_wr(7);
    sw_wr = 1'b1;
    cycles(40);
    chk("man_cnt", 32'(wr_cnt - base), 1);
    chk("man_rom_addr", 32'(rom_addr), 7);
    chk("man_sb", 32'(sb.size()), 0);
    sw_wr = 1'b0;
    cycles(30);

    // 3: full sweep
    base = wr_cnt;
    dbase = done_cnt;
    busy_cnt = 0;
    push_sweep();
    btn_copy = 1'b1;
    cycles(20);
    btn_copy = 1'b0;
    wait_done(dbase, 200);
    cycles(5);
    chk("swp_cnt", 32'(wr_cnt - base), 32);
    chk("swp_busy", 32'(busy_cnt), 33);
    chk("swp_done", 32'(done_cnt - dbase), 1);
    chk("swp_sb", 32'(sb.size()), 0);
    chk("swp_rom_back", 32'(rom_addr), 7);
    cycles(30);

    // 4: bounce then stable high, then short glitch
    base = wr_cnt;
    push_wr(7);
    for (int i = 0; i < 13; i++) begin
      sw_wr = ~sw_wr;
      cycles(3);
    end
    sw_wr = 1'b1;
    cycles(40);
    chk("bnc_cnt", 32'(wr_cnt - base), 1);
    sw_wr = 1'b0;
    cycles(30);
    base = wr_cnt;
    sw_wr = 1'b1;
    cycles(10);
    sw_wr = 1'b0;
    cycles(40);
    chk("glitch_cnt", 32'(wr_cnt - base), 0);
    chk("bnc_sb", 32'(sb.size()), 0);

    // 5a: simultaneous rise, copy wins
    base = wr_cnt;
    dbase = done_cnt;
    push_sweep();
    sw_wr    = 1'b1;
    btn_copy = 1'b1;
    cycles(20);
    btn_copy = 1'b0;
    wait_done(dbase, 200);
    cycles(40);
    chk("col_cnt", 32'(wr_cnt - base), 32);
    sw_wr = 1'b0;
    cycles(30);

    // 5b: manual edge during a sweep is ignored
    base = wr_cnt;
    dbase = done_cnt;
    push_sweep();
    btn_copy = 1'b1;
    cycles(20);
    btn_copy = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk);
      #1 hit = busy;
    end
    chk("mid_busy", 32'(hit), 1);
    sw_wr = 1'b1;
    wait_done(dbase, 200);
    cycles(40);
    chk("mid_cnt", 32'(wr_cnt - base), 32);
    chk("mid_sb", 32'(sb.size()), 0);
    sw_wr = 1'b0;
    cycles(30);

    // 6: reset during write #10 of a sweep
    push_sweep();
    btn_copy = 1'b1;
    cycles(20);
    btn_copy = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #1 hit = ram_wen && (ram_waddr == 5'd9);
    end
    chk("rst10_reach", 32'(hit), 1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst10_wen", 32'(ram_wen), 0);
    chk("rst10_busy", 32'(busy), 0);
    chk("rst10_rom", 32'(rom_addr), 0);
    sb.delete();
    cycles(3);
    base = wr_cnt;
    n_rst = 1'b1;
    cycles(100);
    chk("rst10_after", 32'(wr_cnt - base), 0);
    chk("rst10_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
